// File: rtl/router_pkg.sv
// Shared router definitions: packet width, packet type and the output-arbiter state encoding.
package router_pkg;

    localparam int DATA_WIDTH = 36;

    typedef logic [DATA_WIDTH-1:0] packet_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        SEND    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr+1, modulo NUM_IN.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [IDX_W-1:0]  i_rr_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_valid
);
    import router_pkg::*;

    localparam logic [IDX_W:0] LP_NUM = (IDX_W+1)'(NUM_IN);

    logic [IDX_W-1:0]  w_cand_idx [NUM_IN];
    logic [NUM_IN-1:0] w_cand_req;

    // Candidate gi is the input at distance gi+1 from the pointer; one wrap subtraction suffices.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum            = {1'b0, i_rr_ptr} + (IDX_W+1)'(gi + 1);
            assign w_cand_idx[gi]   = (w_sum >= LP_NUM) ? IDX_W'(w_sum - LP_NUM) : IDX_W'(w_sum);
            assign w_cand_req[gi]   = i_req[w_cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        o_valid     = 1'b0;
        o_grant_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_onehot
            assign o_grant[gi] = o_valid && (o_grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_output_arbiter.sv
// Drains NUM_IN upstream FIFOs round-robin, one packet at a time, into one downstream FIFO write port.
module fifo_output_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_empty,
    output logic [NUM_IN-1:0]            in_read_req,
    input  logic [NUM_IN-1:0]            in_read_gnt,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_packet,
    output logic                         out_write_req,
    input  logic                         out_write_gnt,
    input  logic                         out_full,
    output logic [DATA_WIDTH-1:0]        out_packet,
    output logic [$clog2(NUM_IN)-1:0]    grant_idx,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         pkt_count
);
    import router_pkg::*;

    localparam int IDX_W = $clog2(NUM_IN);

    arb_state_t             r_state;
    logic                   r_rd_armed;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [NUM_IN-1:0]      r_read_req;
    logic                   r_write_req;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic [CNT_WIDTH-1:0]   r_pkt_count;
    logic                   r_busy;

    arb_state_t             w_state_next;
    logic                   w_rd_armed_next;
    logic [IDX_W-1:0]       w_rr_ptr_next;
    logic [IDX_W-1:0]       w_grant_idx_next;
    logic [NUM_IN-1:0]      w_read_req_next;
    logic                   w_write_req_next;
    logic [DATA_WIDTH-1:0]  w_hold_next;
    logic [CNT_WIDTH-1:0]   w_pkt_count_next;

    logic [NUM_IN-1:0]      w_arb_grant;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_valid;
    logic [DATA_WIDTH-1:0]  w_slice [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
            assign w_slice[gi] = in_packet[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .i_req       (~in_empty),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_valid     (w_arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd_armed  <= 1'b0;
            r_rr_ptr    <= IDX_W'(NUM_IN - 1);
            r_grant_idx <= '0;
            r_read_req  <= '0;
            r_write_req <= 1'b0;
            r_hold      <= '0;
            r_pkt_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_armed  <= w_rd_armed_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_grant_idx <= w_grant_idx_next;
            r_read_req  <= w_read_req_next;
            r_write_req <= w_write_req_next;
            r_hold      <= w_hold_next;
            r_pkt_count <= w_pkt_count_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rd_armed_next  = 1'b0;
        w_rr_ptr_next    = r_rr_ptr;
        w_grant_idx_next = r_grant_idx;
        w_read_req_next  = '0;
        w_write_req_next = 1'b0;
        w_hold_next      = r_hold;
        w_pkt_count_next = r_pkt_count;
        case (r_state)
            IDLE: begin
                if (w_arb_valid && !out_full) begin
                    w_read_req_next  = w_arb_grant;
                    w_grant_idx_next = w_arb_idx;
                    w_state_next     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // First cycle only presents the request; the FIFO's registered grant arrives one cycle later.
                if (!r_rd_armed) begin
                    w_rd_armed_next = 1'b1;
                end else if (in_read_gnt[r_grant_idx]) begin
                    w_hold_next      = w_slice[r_grant_idx];
                    w_rr_ptr_next    = r_grant_idx;
                    w_write_req_next = 1'b1;
                    w_state_next     = SEND;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                if (out_write_gnt) begin
                    w_pkt_count_next = r_pkt_count + CNT_WIDTH'(1);
                    w_state_next     = IDLE;
                end else begin
                    w_write_req_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign in_read_req   = r_read_req;
    assign out_write_req = r_write_req;
    assign out_packet    = r_hold;
    assign grant_idx     = r_grant_idx;
    assign busy          = r_busy;
    assign pkt_count     = r_pkt_count;

endmodule

// File: doc/fifo_output_arbiter.md
# fifo_output_arbiter

Round-robin arbiter that drains up to `NUM_IN` router input FIFOs and forwards one 36-bit packet at a time onto a single output link. The output link is the write port of the next router's input FIFO. The block sits directly downstream of the input FIFOs. It drives their `read_req`/`read_gnt` read port and their `write_req`/`write_gnt` write port, using exactly the FIFO handshake semantics.

## Interface
- `NUM_IN`, default 4: number of upstream FIFOs (2..8).
- `DATA_WIDTH`, default 36: packet width; comes from the shared package.
- `CNT_WIDTH`, default 16: width of the forwarded-packet counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_empty`  in  NUM_IN  empty flag of each upstream FIFO.
- `in_read_req`  out  NUM_IN  one-hot read request to the upstream FIFOs.
- `in_read_gnt`  in  NUM_IN  read grant from each FIFO; data valid in the same cycle.
- `in_packet`  in  NUM_IN*DATA_WIDTH  flattened FIFO outputs; FIFO i occupies bits [i*36 +: 36]. Floating when not granted.
- `out_write_req`  out  1  write request to the downstream FIFO.
- `out_write_gnt`  in  1  downstream write grant.
- `out_full`  in  1  downstream full flag.
- `out_packet`  out  DATA_WIDTH  packet presented to the downstream FIFO.
- `grant_idx`  out  $clog2(NUM_IN)  index of the current or last served input.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_count`  out  CNT_WIDTH  number of packets delivered downstream.

## Operation
- FSM states: IDLE, RD_WAIT, SEND.
- **IDLE:** A request vector is formed as `~in_empty`. If the vector is non-zero and `out_full`=0, the arbiter selects the first non-empty input at or after `rr_ptr+1`, modulo `NUM_IN`. It then drives the `in_read_req` bit for that input high for exactly one cycle, latches `grant_idx`, and moves to RD_WAIT.
- **RD_WAIT:** If `in_read_gnt[grant_idx]`=1, the arbiter captures that input's `in_packet` slice into the hold register, sets `rr_ptr`←`grant_idx`, and moves to SEND. Otherwise it returns to IDLE; this is the defensive path, no data is taken, and `rr_ptr` is unchanged.
- **SEND:** `out_write_req`=1 and `out_packet`=hold register, both stable until `out_write_gnt`=1 is sampled. On that edge the arbiter drops `out_write_req`, increments `pkt_count`, and moves to IDLE.
- `out_write_req` is low for at least one cycle between packets, so the downstream FIFO re-arms its grant enable. This low cycle is guaranteed by the path through IDLE.
- `in_packet` bits are never used outside the capture cycle, so floating values are don't-care.
- Only one `in_read_req` bit is ever high. No bit is high outside the issuing cycle.
- `pkt_count` wraps modulo 2^CNT_WIDTH.

## Timing
- **Reset** (`rst_n`=0 at an edge): state goes to IDLE, and `rr_ptr` is set to `NUM_IN-1` so that input 0 is served first. All outputs go to 0: `in_read_req`, `out_write_req`, `out_packet`, `grant_idx`, `busy`, `pkt_count`.
- Reset mid-packet discards the held packet. The upstream read already completed, so that packet is lost by design.
- **Latency:** edge 0, IDLE issues the read; edge 1, the FIFO registers the grant; edge 2, capture; edge 3, `out_write_req` is visible. This gives at least 4 cycles per packet, and more when `out_write_gnt` is delayed.
- `out_full` is only checked in IDLE. Once in SEND, the block waits indefinitely for `out_write_gnt`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Simultaneous events:** when several inputs are non-empty, round-robin order applies. An input that becomes non-empty during RD_WAIT or SEND is considered at the next IDLE.

## Structure
- Shared package `router_pkg` holds:
  - `DATA_WIDTH`=36
  - the packet typedef `packet_t` (`logic [35:0]`)
  - the state enum `arb_state_t` (IDLE/RD_WAIT/SEND)
- Sub-module `rr_arbiter` is purely combinational. Its inputs are the request vector and `rr_ptr`; its outputs are a one-hot grant, the grant index, and a valid flag. The top level owns the FSM, the hold register, and the counter.

## Test plan
- **Single input:** only FIFO 2 is non-empty, holding 36'h0_1234_5678. Required response:
  - `in_read_req`=4'b0100 for one cycle
  - `out_packet`=36'h012345678 with `out_write_req`=1
  - downstream grant one cycle later
  - `pkt_count`=1
- **Fairness:** all 4 FIFOs are non-empty, each with 3 packets. Forward order must be 0,1,2,3,0,1,2,3,0,1,2,3, ending with `pkt_count`=12.
- **Backpressure:** `out_full`=1 while FIFO 0 is non-empty. No `in_read_req` is issued. After `out_full` is released, exactly one read is issued.
- **Delayed grant:** hold `out_write_gnt`=0 for 5 cycles in SEND. `out_write_req` and `out_packet` must stay stable throughout. The block returns to IDLE one edge after the grant.
- **Missing read grant:** force `in_read_gnt`=0 in RD_WAIT. The FSM returns to IDLE, `rr_ptr` and `pkt_count` are unchanged, and no `out_write_req` is driven.
- **Reset mid-SEND:** drive `rst_n`=0 for one cycle. All outputs read 0 on the next cycle, and the next service goes to input 0.
